fix_parser_tokenizer: RTL
=========================

# fix_parser_tokenizer

Byte-stream front end of the FIX parser. Sits directly upstream of the tag/value extraction stage. Accepts raw FIX bytes through a valid/ready handshake, splits them on `=` and SOH, and buffers each field. It then replays each field as one gap-free burst with `start_tag_o`/`start_value_o` framing, followed by one idle cycle. It also checks the FIX tag-10 checksum of each message.

## Interface
- `MAX_TAG`, 4: maximum tag length in bytes; matches the 32-bit tag register downstream.
- `MAX_VAL`, 32: maximum value length in bytes; matches the 256-bit value register downstream.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `data_i` input 8: raw FIX byte.
- `valid_i` input 1: `data_i` is valid.
- `ready_o` output 1: byte accepted when `valid_i && ready_o`.
- `data_o` output 8: field byte to the downstream stage.
- `start_tag_o` output 1: `data_o` is a tag byte.
- `start_value_o` output 1: `data_o` is a value byte.
- `msg_done_o` output 1: one-cycle pulse when the tag-10 field is finished.
- `checksum_ok_o` output 1: checksum result; valid while `msg_done_o` is high.
- `err_o` output 1: one-cycle pulse on a framing error.

## Operation
- States:
  - `TAG_COL`: collect tag bytes.
  - `TAG_EMIT`: replay tag bytes.
  - `TAG_GAP`: one idle cycle after the tag.
  - `VAL_COL`: collect value bytes.
  - `VAL_EMIT`: replay value bytes.
  - `VAL_GAP`: one idle cycle after the value.
  - `DISCARD`: drop bytes until SOH.
- Reset state is `TAG_COL`.
- `TAG_COL` (`ready_o=1`):
  - Bytes other than `=` and SOH are stored in the tag buffer.
  - `=` with 1..`MAX_TAG` bytes stored → `TAG_EMIT`.
  - `=` with no bytes stored → `err_o`, go to `DISCARD`.
  - SOH → `err_o`, clear buffer, stay in `TAG_COL`.
  - A byte arriving while `MAX_TAG` bytes are already stored → `err_o`, go to `DISCARD`.
- `TAG_EMIT` (`ready_o=0`):
  - One stored byte per cycle, oldest first, `start_tag_o=1`.
  - After the last byte → `TAG_GAP`.
- `TAG_GAP`: all framing outputs 0 for one cycle, then `VAL_COL`.
- `VAL_COL` (`ready_o=1`):
  - All bytes other than SOH are stored (a second `=` is value data).
  - SOH with 1..`MAX_VAL` bytes stored → `VAL_EMIT`.
  - SOH with no bytes stored → `err_o`; a single byte 8'h00 is stored and emitted so the downstream stage always receives a value.
  - A byte arriving while `MAX_VAL` bytes are already stored → `err_o`; the `MAX_VAL` stored bytes are emitted, then the block enters `DISCARD`.
- `VAL_EMIT` (`ready_o=0`): bytes oldest first with `start_value_o=1`, then `VAL_GAP`.
- `VAL_GAP`: framing outputs 0 for one cycle, then `TAG_COL`, or `DISCARD` if a value overflow is pending.
- `DISCARD` (`ready_o=1`): bytes are accepted and dropped; SOH → `TAG_COL`.
- Checksum:
  - `sum` is 8 bits, wraps modulo 256, and adds every accepted byte.
  - When the tag `"8"` completes, `sum` is reloaded with 8'h38 + 8'h3D.
  - On every accepted SOH, `snap` latches the post-add `sum`.
  - When the tag `"10"` completes, the field's value is the expected checksum. It must be exactly 3 ASCII digits. The decimal value is compared with `snap`.
  - In the `VAL_GAP` of that field: `msg_done_o=1`, and `checksum_ok_o=1` only when the digits are valid and equal to `snap`.
- Outputs are 0 when not framed: `data_o=0` outside the emit states.

## Timing
- All outputs reset to 0.
- A field of N stored bytes needs N emit cycles plus 1 gap cycle after its delimiter is accepted.
- Throughput is fields serialized: input is stalled (`ready_o=0`) during the emit and gap states.
- `valid_i` may drop mid-field. Output bursts are never interrupted, because the downstream stage treats a low framing strobe as end of field.
- Reset asserted mid-burst: the burst is abandoned immediately. Framing outputs go to 0 asynchronously, and buffers and checksum are cleared.
- `msg_done_o` and `err_o` never coincide with `start_tag_o` or `start_value_o`, except for value-overflow `err_o`, which is asserted in `VAL_COL`.

## Structure
- `fix_pkg` holds:
  - constants: `SOH=8'h01`, `EQ=8'h3D`, `TAG_BEGIN="8"`, `TAG_CKSUM="10"`;
  - the state enum;
  - `MAX_TAG` and `MAX_VAL` defaults.
- One sub-module, `fix_field_buf`: a byte buffer with write pointer, read pointer, count, and overflow flag, instantiated for tag and for value.

## Test plan
- `"8=FIX.4.2<SOH>"` with `valid_i` held high:
  - `start_tag_o` high for 1 cycle carrying 8'h38, then 1 gap cycle.
  - `start_value_o` high for 7 cycles carrying `F,I,X,.,4,.,2`, then 1 gap cycle.
- Full message `8=FIX.4.2<SOH>9=5<SOH>35=0<SOH>10=ccc<SOH>`, with `ccc` computed by the bench: `msg_done_o=1` and `checksum_ok_o=1`. The same message with `ccc` off by one gives `checksum_ok_o=0`.
- `valid_i` toggled every other cycle inside the value `"12345"`: the output burst is still 5 contiguous cycles, and `ready_o` is 0 throughout it.
- Tag `"12345="`: `err_o` pulses on the 5th tag byte, nothing is emitted, and the next field parses normally after SOH.
- 40-byte value: `err_o` pulses; 32 bytes are emitted, the remaining 8 are dropped, and resync happens at SOH.
- `rst_n` asserted low during `VAL_EMIT`: outputs go to 0 immediately; after release, `"8=A<SOH>"` parses correctly.

Source files
------------

// File: rtl/fix_pkg.sv
// Shared constants and state type for the FIX byte tokenizer.
// Imported by the field buffer and the tokenizer top.
package fix_pkg;

  localparam logic [7:0]  SOH       = 8'h01;
  localparam logic [7:0]  EQ        = 8'h3D;
  localparam logic [7:0]  TAG_BEGIN = "8";
  localparam logic [15:0] TAG_CKSUM = "10";
  localparam logic [7:0]  SUM_BEGIN = TAG_BEGIN + EQ;

  localparam int MAX_TAG_DEF = 4;
  localparam int MAX_VAL_DEF = 32;

  typedef enum logic [2:0] {
    TAG_COL,
    TAG_EMIT,
    TAG_GAP,
    VAL_COL,
    VAL_EMIT,
    VAL_GAP,
    DISCARD
  } fix_state_e;

endpackage

// File: rtl/fix_field_buf.sv
// Byte buffer for one FIX field: filled in order, replayed oldest first.
// A write while full sets the sticky overflow flag instead of storing.
module fix_field_buf
  import fix_pkg::*;
#(
  parameter int DEPTH = MAX_TAG_DEF,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          wr,
  input  logic [7:0]    wdata,
  input  logic          rd,
  output logic [7:0]    rdata,
  output logic [15:0]   head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          last,
  output logic          ovf
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          store;

  assign full  = count == CW'(DEPTH);
  assign store = wr && !full && !clr;
  assign last  = (CW'(rd_ptr) + CW'(1)) == count;
  assign rdata = mem[rd_ptr];
  assign head  = {mem[1], mem[0]};

  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr && full) ovf <= 1'b1;
      if (store) begin
        wr_ptr <= wr_ptr + PW'(1);
        count  <= count + CW'(1);
      end
      if (rd) rd_ptr <= rd_ptr + PW'(1);
    end
  end

endmodule

// File: rtl/fix_parser_tokenizer.sv
// FIX byte tokenizer: splits on '=' / SOH, replays each field as a
// gap-free burst and verifies the tag-10 checksum of every message.
module fix_parser_tokenizer
  import fix_pkg::*;
#(
  parameter int MAX_TAG = MAX_TAG_DEF,
  parameter int MAX_VAL = MAX_VAL_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic [7:0] data_o,
  output logic       start_tag_o,
  output logic       start_value_o,
  output logic       msg_done_o,
  output logic       checksum_ok_o,
  output logic       err_o
);

  localparam int TW = $clog2(MAX_TAG + 1);
  localparam int VW = $clog2(MAX_VAL + 1);

  fix_state_e state, state_nx;

  logic          run, acc, is_soh, is_eq;
  logic          t_clr, t_wr, t_rd, t_full, t_last, t_ovf;
  logic          v_clr, v_wr, v_rd, v_full, v_last, v_ovf;
  logic [7:0]    t_rdata, v_rdata, v_wdata;
  logic [15:0]   t_head, v_head;
  logic [TW-1:0] t_cnt;
  logic [VW-1:0] v_cnt;

  logic [7:0] sum, snap, ck_ref, dig;
  logic [9:0] ck_num;
  logic       ck_bad, is_ck, is_dig;
  logic       tag_done, tag_8, tag_10;
  logic       unused_ok;

  assign is_soh = data_i == SOH;
  assign is_eq  = data_i == EQ;
  assign dig    = data_i - 8'h30;
  assign is_dig = dig < 8'd10;

  assign ready_o = run && (state == TAG_COL ||
                           state == VAL_COL ||
                           state == DISCARD);
  assign acc = valid_i && ready_o;

  assign tag_8  = t_cnt == TW'(1) && t_head[7:0] == TAG_BEGIN;
  assign tag_10 = t_cnt == TW'(2) &&
                  {t_head[7:0], t_head[15:8]} == TAG_CKSUM;
  assign tag_done = acc && state == TAG_COL &&
                    is_eq && t_cnt != '0;

  // An empty value is replaced by a single 00 byte.
  assign v_wdata = is_soh ? 8'h00 : data_i;

  assign unused_ok = ^{t_ovf, v_head};

  fix_field_buf #(.DEPTH(MAX_TAG), .CW(TW)) u_tag (
    .clk(clk), .rst_n(rst_n),
    .clr(t_clr), .wr(t_wr), .wdata(data_i), .rd(t_rd),
    .rdata(t_rdata), .head(t_head), .count(t_cnt),
    .full(t_full), .last(t_last), .ovf(t_ovf)
  );

  fix_field_buf #(.DEPTH(MAX_VAL), .CW(VW)) u_val (
    .clk(clk), .rst_n(rst_n),
    .clr(v_clr), .wr(v_wr), .wdata(v_wdata), .rd(v_rd),
    .rdata(v_rdata), .head(v_head), .count(v_cnt),
    .full(v_full), .last(v_last), .ovf(v_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= TAG_COL;
      run   <= 1'b0;
    end else begin
      state <= state_nx;
      run   <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    err_o    = 1'b0;
    t_clr    = 1'b0;
    t_wr     = 1'b0;
    t_rd     = 1'b0;
    v_clr    = 1'b0;
    v_wr     = 1'b0;
    v_rd     = 1'b0;
    unique case (state)
      TAG_COL: if (acc) begin
        if (is_soh) begin
          err_o = 1'b1;
          t_clr = 1'b1;
        end else if (is_eq) begin
          if (t_cnt == '0) begin
            err_o    = 1'b1;
            state_nx = DISCARD;
          end else begin
            state_nx = TAG_EMIT;
          end
        end else if (t_full) begin
          err_o    = 1'b1;
          t_clr    = 1'b1;
          state_nx = DISCARD;
        end else begin
          t_wr = 1'b1;
        end
      end
      TAG_EMIT: begin
        t_rd = 1'b1;
        if (t_last) state_nx = TAG_GAP;
      end
      TAG_GAP: begin
        t_clr    = 1'b1;
        state_nx = VAL_COL;
      end
      VAL_COL: if (acc) begin
        if (is_soh) begin
          if (v_cnt == '0) begin
            err_o = 1'b1;
            v_wr  = 1'b1;
          end
          state_nx = VAL_EMIT;
        end else begin
          // Overflow write only sets the sticky flag.
          v_wr = 1'b1;
          if (v_full) begin
            err_o    = 1'b1;
            state_nx = VAL_EMIT;
          end
        end
      end
      VAL_EMIT: begin
        v_rd = 1'b1;
        if (v_last) state_nx = VAL_GAP;
      end
      VAL_GAP: begin
        v_clr    = 1'b1;
        state_nx = v_ovf ? DISCARD : TAG_COL;
      end
      DISCARD: if (acc && is_soh) state_nx = TAG_COL;
      default: state_nx = TAG_COL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum    <= '0;
      snap   <= '0;
      ck_ref <= '0;
      ck_num <= '0;
      ck_bad <= 1'b0;
      is_ck  <= 1'b0;
    end else begin
      if (acc)
        sum <= (tag_done && tag_8) ? SUM_BEGIN : sum + data_i;
      if (acc && is_soh) snap <= sum + data_i;
      // snap still holds the sum up to the SOH before "10=".
      if (tag_done) begin
        is_ck  <= tag_10;
        ck_ref <= snap;
        ck_num <= '0;
        ck_bad <= 1'b0;
      end else if (acc && state == VAL_COL && !is_soh) begin
        ck_num <= ck_num * 10'd10 + {2'b00, dig};
        ck_bad <= ck_bad | !is_dig;
      end
    end
  end

  always_comb begin
    data_o = 8'h00;
    if (state == TAG_EMIT) data_o = t_rdata;
    if (state == VAL_EMIT) data_o = v_rdata;
  end

  assign start_tag_o   = state == TAG_EMIT;
  assign start_value_o = state == VAL_EMIT;
  assign msg_done_o    = state == VAL_GAP && is_ck;
  assign checksum_ok_o = msg_done_o && !ck_bad &&
                         v_cnt == VW'(3) &&
                         ck_num == {2'b00, ck_ref};

endmodule
